// File: rtl/c5_ram_dp_if.sv
// c5_ram_dp_if: request/response bundle for the c5 dual-port RAM.
//   Port A (load/store): I_a_valid, O_a_ready, I_a_addr, I_a_wbe, I_a_wdata,
//                        O_a_rdata, O_a_rvalid
//   Port B (fetch):      I_b_valid, O_b_ready, I_b_addr, O_b_rdata, O_b_rvalid
//   Status:              O_init_done
// I_/O_ prefixes are relative to the RAM; the RAM uses the slave modport.
interface c5_ram_dp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
);
    logic                      I_a_valid;
    logic                      O_a_ready;
    logic [DEPTH_LOG2-1:0]     I_a_addr;
    logic [DATA_WIDTH/8-1:0]   I_a_wbe;
    logic [DATA_WIDTH-1:0]     I_a_wdata;
    logic [DATA_WIDTH-1:0]     O_a_rdata;
    logic                      O_a_rvalid;

    logic                      I_b_valid;
    logic                      O_b_ready;
    logic [DEPTH_LOG2-1:0]     I_b_addr;
    logic [DATA_WIDTH-1:0]     O_b_rdata;
    logic                      O_b_rvalid;

    logic                      O_init_done;

    modport master (
        output I_a_valid, I_a_addr, I_a_wbe, I_a_wdata, I_b_valid, I_b_addr,
        input  O_a_ready, O_a_rdata, O_a_rvalid, O_b_ready, O_b_rdata, O_b_rvalid,
               O_init_done
    );

    modport slave (
        input  I_a_valid, I_a_addr, I_a_wbe, I_a_wdata, I_b_valid, I_b_addr,
        output O_a_ready, O_a_rdata, O_a_rvalid, O_b_ready, O_b_rdata, O_b_rvalid,
               O_init_done
    );
endinterface

// File: rtl/c5_ram_dp.sv
// c5_ram_dp: dual-port byte-enabled RAM. Port A read/write, port B read-only,
// both with 1-cycle read latency. After reset an init FSM clears every word
// (default) or, with C5_RAM_BOOT_LOAD_EN defined, copies a boot image from an
// external ROM (1-cycle latency); both ports stay not-ready until it finishes.
// Ports:
//   I_clk, I_rst    clock, synchronous active-high reset
//   bus             c5_ram_dp_if.slave (port A, port B, O_init_done)
//   O_boot_addr     boot ROM word address   (C5_RAM_BOOT_LOAD_EN only)
//   I_boot_data     boot ROM data           (C5_RAM_BOOT_LOAD_EN only)
module c5_ram_dp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    c5_ram_dp_if.slave            bus
`ifdef C5_RAM_BOOT_LOAD_EN
    ,
    output logic [DEPTH_LOG2-1:0] O_boot_addr,
    input  logic [DATA_WIDTH-1:0] I_boot_data
`endif
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam int unsigned NUM_WORDS = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [DEPTH_LOG2-1:0]   cnt_q;
    logic                    ready_q;
    logic                    init_done_q;
    logic                    a_rvalid_q;
    logic                    b_rvalid_q;
    logic [DATA_WIDTH-1:0]   a_rdata_q;
    logic [DATA_WIDTH-1:0]   b_rdata_q;

    logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];

    logic                    a_wr_c;
    logic                    a_rd_c;
    logic                    b_rd_c;
    logic [NUM_LANES-1:0]    wr_be_c;
    logic [DEPTH_LOG2-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic [DATA_WIDTH-1:0]   b_word_c;

    // Request acceptance; ready is only ever high in S_RUN.
    always_comb begin
        a_wr_c = bus.I_a_valid & ready_q & (|bus.I_a_wbe);
        a_rd_c = bus.I_a_valid & ready_q & ~(|bus.I_a_wbe);
        b_rd_c = bus.I_b_valid & ready_q;
    end

    // Single write port shared between the init sequencer and port A.
    always_comb begin
        wr_be_c   = '0;
        wr_addr_c = bus.I_a_addr;
        wr_data_c = bus.I_a_wdata;
        if (I_rst) begin
            wr_be_c = '0;
        end else if (state_q == S_RUN) begin
            if (a_wr_c) begin
                wr_be_c = bus.I_a_wbe;
            end
        end else begin
`ifdef C5_RAM_BOOT_LOAD_EN
            // ROM data lags the issued address by one cycle; the final word
            // lands in S_DRAIN after the counter has wrapped to zero.
            wr_addr_c = cnt_q - DEPTH_LOG2'(1);
            wr_data_c = I_boot_data;
            if ((state_q == S_DRAIN) || (cnt_q != '0)) begin
                wr_be_c = '1;
            end
`else
            wr_addr_c = cnt_q;
            wr_data_c = '0;
            wr_be_c   = '1;
`endif
        end
    end

    // Port B sees a same-cycle port A write on the enabled lanes (write-first).
    always_comb begin
        b_word_c = mem[bus.I_b_addr];
        if (a_wr_c && (bus.I_a_addr == bus.I_b_addr)) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (bus.I_a_wbe[i]) begin
                    b_word_c[8*i +: 8] = bus.I_a_wdata[8*i +: 8];
                end
            end
        end
    end

    // Storage array, byte-lane writes.
    always_ff @(posedge I_clk) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (wr_be_c[i]) begin
                mem[wr_addr_c][8*i +: 8] <= wr_data_c[8*i +: 8];
            end
        end
    end

    // Init FSM plus registered read outputs.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            a_rvalid_q <= a_rd_c;
            b_rvalid_q <= b_rd_c;
            if (a_rd_c) begin
                a_rdata_q <= mem[bus.I_a_addr];
            end
            if (b_rd_c) begin
                b_rdata_q <= b_word_c;
            end
            case (state_q)
                S_FILL: begin
                    cnt_q <= cnt_q + DEPTH_LOG2'(1);
                    if (cnt_q == '1) begin
`ifdef C5_RAM_BOOT_LOAD_EN
                        state_q <= S_DRAIN;
`else
                        state_q     <= S_RUN;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
`endif
                    end
                end
                S_DRAIN: begin
                    state_q     <= S_RUN;
                    ready_q     <= 1'b1;
                    init_done_q <= 1'b1;
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

    assign bus.O_a_ready   = ready_q;
    assign bus.O_b_ready   = ready_q;
    assign bus.O_a_rdata   = a_rdata_q;
    assign bus.O_b_rdata   = b_rdata_q;
    assign bus.O_a_rvalid  = a_rvalid_q;
    assign bus.O_b_rvalid  = b_rvalid_q;
    assign bus.O_init_done = init_done_q;
`ifdef C5_RAM_BOOT_LOAD_EN
    assign O_boot_addr     = cnt_q;
`endif

endmodule

// File: tb/tb_c5_ram_dp.sv
// Testbench for c5_ram_dp: reset values, init length, ignored requests during
// init, a vector table of directed cases, back-to-back bursts, randomized
// traffic against an array model, and a mid-run reset.
module tb_c5_ram_dp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;
`ifdef C5_RAM_BOOT_LOAD_EN
    localparam int unsigned INIT_CYCLES = DEPTH + 1;
`else
    localparam int unsigned INIT_CYCLES = DEPTH;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c5_ram_dp_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) bus ();

`ifdef C5_RAM_BOOT_LOAD_EN
    logic [AW-1:0] boot_addr;
    logic [DW-1:0] boot_data;
    always @(posedge clk) boot_data <= 32'hA500_0000 | 32'(boot_addr);
`endif

    c5_ram_dp #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .bus         (bus)
`ifdef C5_RAM_BOOT_LOAD_EN
        ,
        .O_boot_addr (boot_addr),
        .I_boot_data (boot_data)
`endif
    );

    int          checks;
    int          errors;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] hold_a;
    logic [31:0] hold_b;

    typedef struct {
        logic        av;
        logic [3:0]  wbe;
        logic [9:0]  aa;
        logic [31:0] wd;
        logic        bv;
        logic [9:0]  ba;
        logic        a_rv;
        logic [31:0] a_rd;
        logic        b_rv;
        logic [31:0] b_rd;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [31:0] init_val(input int unsigned a);
`ifdef C5_RAM_BOOT_LOAD_EN
        return 32'hA500_0000 | 32'(a);
`else
        return 32'h0 + 32'(a) * 32'h0;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wbe);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (wbe[i]) w[8*i +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [3:0] wbe, input logic [9:0] aa,
                         input logic [31:0] wd, input logic bv, input logic [9:0] ba);
        bus.I_a_valid = av;
        bus.I_a_wbe   = wbe;
        bus.I_a_addr  = aa;
        bus.I_a_wdata = wd;
        bus.I_b_valid = bv;
        bus.I_b_addr  = ba;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
    endtask

    // One cycle of traffic while the RAM is running, expectations from the array model.
    task automatic step_model(input logic av, input logic [3:0] wbe, input logic [9:0] aa,
                              input logic [31:0] wd, input logic bv, input logic [9:0] ba,
                              input string tag);
        logic exp_arv;
        drive(av, wbe, aa, wd, bv, ba);
        exp_arv = av && (wbe == 4'h0);
        if (av && (wbe != 4'h0)) ref_mem[aa] = merge(ref_mem[aa], wd, wbe);
        if (exp_arv) hold_a = ref_mem[aa];
        if (bv)      hold_b = ref_mem[ba];
        tick();
        chk({tag, " a_rvalid"}, 32'(bus.O_a_rvalid), 32'(exp_arv));
        chk({tag, " b_rvalid"}, 32'(bus.O_b_rvalid), 32'(bv));
        chk({tag, " a_rdata"},  bus.O_a_rdata, hold_a);
        chk({tag, " b_rdata"},  bus.O_b_rdata, hold_b);
    endtask

    // Release reset and count cycles to init_done while hammering both ports.
    task automatic run_init(input string tag);
        int n;
        int bad_rv;
        int bad_rdy;
        n       = 0;
        bad_rv  = 0;
        bad_rdy = 0;
        rst = 1'b0;
        drive(1'b1, 4'hF, 10'd20, 32'hDEAD_BEEF, 1'b1, 10'd20);
        while (n <= int'(INIT_CYCLES) + 20) begin
            tick();
            n++;
            if (bus.O_a_rvalid || bus.O_b_rvalid) bad_rv++;
            if ((bus.O_a_ready !== bus.O_init_done) || (bus.O_b_ready !== bus.O_init_done))
                bad_rdy++;
            if (bus.O_init_done) break;
        end
        idle();
        chk({tag, " init length"}, 32'(n), 32'(INIT_CYCLES));
        chk({tag, " rvalid during init"}, 32'(bad_rv), 32'd0);
        chk({tag, " ready vs init_done"}, 32'(bad_rdy), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
        hold_a = 32'h0;
        hold_b = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();

        chk("reset a_rdata",   bus.O_a_rdata, 32'h0);
        chk("reset b_rdata",   bus.O_b_rdata, 32'h0);
        chk("reset a_rvalid",  32'(bus.O_a_rvalid), 32'h0);
        chk("reset b_rvalid",  32'(bus.O_b_rvalid), 32'h0);
        chk("reset a_ready",   32'(bus.O_a_ready), 32'h0);
        chk("reset b_ready",   32'(bus.O_b_ready), 32'h0);
        chk("reset init_done", 32'(bus.O_init_done), 32'h0);
`ifdef C5_RAM_BOOT_LOAD_EN
        chk("reset boot_addr", 32'(boot_addr), 32'h0);
`endif

        run_init("init0");
        chk("run a_ready", 32'(bus.O_a_ready), 32'h1);
        chk("run b_ready", 32'(bus.O_b_ready), 32'h1);

        // Writes attempted during init must not have landed at addr 20.
        step_model(1'b1, 4'h0, 10'd20, 32'h0, 1'b1, 10'd5, "post-init rd20/rd5");
        chk("addr20 untouched", hold_a, init_val(20));
        chk("addr5 init value", hold_b, init_val(5));

        tbl[0] = '{1'b1, 4'hF, 10'd3, 32'hFFFF_FFFF, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 4'h5, 10'd3, 32'h1122_3344, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 4'h0, 10'd3, 32'h0, 1'b0, 10'd0, 1'b1, 32'hFF22_FF44, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 4'hF, 10'd7, 32'h1234_5678, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 4'hC, 10'd7, 32'hAABB_0000, 1'b1, 10'd7, 1'b0, 32'h0, 1'b1, 32'hAABB_5678};
        tbl[5] = '{1'b1, 4'h0, 10'd7, 32'h0, 1'b1, 10'd7, 1'b1, 32'hAABB_5678, 1'b1, 32'hAABB_5678};
        tbl[6] = '{1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3, 1'b0, 32'h0, 1'b1, 32'hFF22_FF44};
        tbl[8] = '{1'b1, 4'hF, 10'd9, 32'hCAFE_F00D, 1'b1, 10'd5, 1'b0, 32'h0, 1'b1, init_val(5)};
        tbl[9] = '{1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 10'd9, 1'b1, init_val(5), 1'b1, 32'hCAFE_F00D};

        for (int v = 0; v < 10; v++) begin
            drive(tbl[v].av, tbl[v].wbe, tbl[v].aa, tbl[v].wd, tbl[v].bv, tbl[v].ba);
            if (tbl[v].av && (tbl[v].wbe != 4'h0))
                ref_mem[tbl[v].aa] = merge(ref_mem[tbl[v].aa], tbl[v].wd, tbl[v].wbe);
            if (tbl[v].a_rv) hold_a = tbl[v].a_rd;
            if (tbl[v].b_rv) hold_b = tbl[v].b_rd;
            tick();
            chk($sformatf("vec%0d a_rvalid", v), 32'(bus.O_a_rvalid), 32'(tbl[v].a_rv));
            chk($sformatf("vec%0d b_rvalid", v), 32'(bus.O_b_rvalid), 32'(tbl[v].b_rv));
            chk($sformatf("vec%0d a_rdata", v),  bus.O_a_rdata, hold_a);
            chk($sformatf("vec%0d b_rdata", v),  bus.O_b_rdata, hold_b);
        end

        // Back-to-back writes on A, then simultaneous read bursts on A and B.
        for (int i = 0; i < 16; i++)
            step_model(1'b1, 4'hF, 10'(i), (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000, 1'b0, 10'd0,
                       $sformatf("burst wr%0d", i));
        for (int i = 0; i < 16; i++)
            step_model(1'b1, 4'h0, 10'(15 - i), 32'h0, 1'b1, 10'(i), $sformatf("burst rd%0d", i));
        idle();
        tick();
        chk("burst end a_rvalid", 32'(bus.O_a_rvalid), 32'h0);
        chk("burst end b_rvalid", 32'(bus.O_b_rvalid), 32'h0);
        chk("burst end b_rdata hold", bus.O_b_rdata, ref_mem[15]);

        // Random traffic over a small window to force address collisions.
        for (int c = 0; c < 400; c++) begin
            logic [3:0] wbe;
            wbe = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
            step_model(1'($urandom), wbe, 10'($urandom % 32), $urandom,
                       1'($urandom), 10'($urandom % 32), $sformatf("rand%0d", c));
        end

        // Mid-burst reset.
        step_model(1'b1, 4'hF, 10'd3, 32'h0BAD_F00D, 1'b0, 10'd0, "pre-reset wr3");
        step_model(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3, "pre-reset rd3a");
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3);
        rst = 1'b1;
        tick();
        chk("midrst b_rvalid",  32'(bus.O_b_rvalid), 32'h0);
        chk("midrst b_rdata",   bus.O_b_rdata, 32'h0);
        chk("midrst a_ready",   32'(bus.O_a_ready), 32'h0);
        chk("midrst b_ready",   32'(bus.O_b_ready), 32'h0);
        chk("midrst init_done", 32'(bus.O_init_done), 32'h0);
        run_init("init1");
        step_model(1'b1, 4'h0, 10'd3, 32'h0, 1'b1, 10'd9, "post-reset rd3/rd9");
        chk("addr3 reinit", hold_a, init_val(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
